// File: rtl/uart_cmd_interface_if.sv
// Command bus between the UART byte streams, the ALU and the command decoder.
// The decoder connects through the slave modport; the UART/ALU side connects through master.
interface uart_cmd_interface_if #(
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_BYTE-1:0] i_rx;
    logic               i_rxDone;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_error;
    logic               o_busy;

    modport master (
        output i_rx, i_rxDone, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_error, o_busy
    );

    modport slave (
        input  i_rx, i_rxDone, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_error, o_busy
    );
endinterface

// File: rtl/uart_cmd_interface.sv
// Header+payload command decoder: loads ALU operands/opcode from UART RX bytes and
// streams a snapshot of the ALU result back over TX, LSB byte first.
module uart_cmd_interface #(
    parameter int unsigned NB_BYTE    = 8,
    parameter int unsigned NB_DATA    = 16,
    parameter int unsigned NB_OP      = 6,
    parameter int unsigned NB_TIMEOUT = 16,
    parameter int unsigned TIMEOUT    = 50000
) (
    input logic                  clk,
    input logic                  i_rst_n,
    uart_cmd_interface_if.slave  bus
);
    localparam int unsigned NBYTES = NB_DATA / NB_BYTE;
    localparam int unsigned CntW   = $clog2(NBYTES + 1);

    localparam logic [NB_BYTE-1:0]    HdrA    = NB_BYTE'(8'h08);
    localparam logic [NB_BYTE-1:0]    HdrB    = NB_BYTE'(8'h10);
    localparam logic [NB_BYTE-1:0]    HdrOp   = NB_BYTE'(8'h20);
    localparam logic [NB_BYTE-1:0]    HdrRd   = NB_BYTE'(8'h40);
    localparam logic [NB_TIMEOUT-1:0] ToutMax = NB_TIMEOUT'(TIMEOUT - 1);
    localparam logic [CntW-1:0]       LastIdx = CntW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StPayload, StSend, StWaitTx} state_e;
    typedef enum logic [1:0] {TgtA, TgtB, TgtOp} target_e;

    state_e                state_q, state_d;
    target_e               target_q, target_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NB_TIMEOUT-1:0] tout_q, tout_d;
    logic [NB_DATA-1:0]    shadow_q, shadow_d;
    logic [NB_DATA-1:0]    snap_q, snap_d;
    logic [NB_DATA-1:0]    data_a_q, data_a_d;
    logic [NB_DATA-1:0]    data_b_q, data_b_d;
    logic [NB_OP-1:0]      op_q, op_d;
    logic [NB_BYTE-1:0]    tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  error_q, error_d;

    // New byte enters at the top so the first (least significant) byte ends up at the bottom.
    logic [NB_BYTE+NB_DATA-1:0] shift_cat;
    logic [NB_DATA-1:0]         shifted;
    logic [NB_DATA-1:0]         snap_shift;
    logic [CntW-1:0]            last_idx;

    assign shift_cat  = {bus.i_rx, shadow_q};
    assign shifted    = shift_cat[NB_BYTE+NB_DATA-1:NB_BYTE];
    assign snap_shift = snap_q >> (NB_BYTE * int'(cnt_q));
    assign last_idx   = (target_q == TgtOp) ? '0 : LastIdx;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        tout_d     = tout_q;
        shadow_d   = shadow_q;
        snap_d     = snap_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.i_rxDone) begin
                    cnt_d    = '0;
                    tout_d   = '0;
                    shadow_d = '0;
                    case (bus.i_rx)
                        HdrA:    begin target_d = TgtA;  state_d = StPayload; end
                        HdrB:    begin target_d = TgtB;  state_d = StPayload; end
                        HdrOp:   begin target_d = TgtOp; state_d = StPayload; end
                        HdrRd:   begin snap_d = bus.i_alu_result; state_d = StSend; end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            StPayload: begin
                if (bus.i_rxDone) begin
                    tout_d   = '0;
                    shadow_d = shifted;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == last_idx) begin
                        case (target_q)
                            TgtA:    data_a_d = shifted;
                            TgtB:    data_b_d = shifted;
                            default: op_d     = bus.i_rx[NB_OP-1:0];
                        endcase
                        shadow_d = '0;
                        state_d  = StIdle;
                    end
                end else if (tout_q == ToutMax) begin
                    error_d  = 1'b1;
                    shadow_d = '0;
                    state_d  = StIdle;
                end else begin
                    tout_d = tout_q + NB_TIMEOUT'(1);
                end
            end
            StSend: begin
                tx_start_d = 1'b1;
                tx_data_d  = snap_shift[NB_BYTE-1:0];
                error_d    = bus.i_rxDone;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                error_d = bus.i_rxDone;
                if (bus.i_tx_done) begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = (cnt_q == LastIdx) ? StIdle : StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            target_q   <= TgtA;
            cnt_q      <= '0;
            tout_q     <= '0;
            shadow_q   <= '0;
            snap_q     <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
            shadow_q   <= shadow_d;
            snap_q     <= snap_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_error    = error_q;
    assign bus.o_busy     = (state_q != StIdle);
endmodule

// File: tb/tb_uart_cmd_interface.sv
// Directed bench for uart_cmd_interface: operand/opcode loads, result readback,
// protocol errors, payload timeout and reset in the middle of a transmission.
module tb_uart_cmd_interface;
    localparam int unsigned NB_BYTE    = 8;
    localparam int unsigned NB_DATA    = 16;
    localparam int unsigned NB_OP      = 6;
    localparam int unsigned NB_TIMEOUT = 16;
    localparam int unsigned TIMEOUT    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    uart_cmd_interface_if #(.NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_cmd_interface #(
        .NB_BYTE    (NB_BYTE),
        .NB_DATA    (NB_DATA),
        .NB_OP      (NB_OP),
        .NB_TIMEOUT (NB_TIMEOUT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx     = b;
        bus.i_rxDone = 1'b1;
        tick();
        bus.i_rxDone = 1'b0;
    endtask

    task automatic tx_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"},     32'(bus.o_data_a),   32'h0);
        check({tag, "_b"},     32'(bus.o_data_b),   32'h0);
        check({tag, "_op"},    32'(bus.o_op),       32'h0);
        check({tag, "_txd"},   32'(bus.o_tx_data),  32'h0);
        check({tag, "_start"}, 32'(bus.o_tx_start), 32'h0);
        check({tag, "_err"},   32'(bus.o_error),    32'h0);
        check({tag, "_busy"},  32'(bus.o_busy),     32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bus.i_rx = '0; bus.i_rxDone = 1'b0; bus.i_tx_done = 1'b0; bus.i_alu_result = '0;
        #12;
        check_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_zero("idle");

        // Load A = 0x0102, LSB byte first
        send(8'h08); send(8'h02); send(8'h01);
        check("load_a",      32'(bus.o_data_a), 32'h0102);
        check("load_a_b",    32'(bus.o_data_b), 32'h0);
        check("load_a_op",   32'(bus.o_op),     32'h0);
        check("load_a_busy", 32'(bus.o_busy),   32'h0);

        send(8'h20); send(8'h22);
        check("load_op", 32'(bus.o_op), 32'h22);
        send(8'h10); send(8'h01); send(8'h01);
        check("load_b",    32'(bus.o_data_b), 32'h0101);
        check("load_b_a",  32'(bus.o_data_a), 32'h0102);
        check("load_b_op", 32'(bus.o_op),     32'h22);

        // Read result with a snapshot; ALU changes mid-transfer must not leak through
        bus.i_alu_result = 16'hBEEF;
        send(8'h40);
        check("rd_busy",    32'(bus.o_busy),     32'h1);
        check("rd_nostart", 32'(bus.o_tx_start), 32'h0);
        tick();
        check("rd_start0", 32'(bus.o_tx_start), 32'h1);
        check("rd_data0",  32'(bus.o_tx_data),  32'hEF);
        tick();
        check("rd_pulse0", 32'(bus.o_tx_start), 32'h0);
        check("rd_hold0",  32'(bus.o_tx_data),  32'hEF);
        bus.i_alu_result = 16'h1234;
        send(8'h77);
        check("rd_rx_err",   32'(bus.o_error), 32'h1);
        tick();
        check("rd_rx_err_1", 32'(bus.o_error), 32'h0);
        check("rd_busy_2",   32'(bus.o_busy),  32'h1);
        tx_done();
        check("rd_gap", 32'(bus.o_tx_start), 32'h0);
        tick();
        check("rd_start1", 32'(bus.o_tx_start), 32'h1);
        check("rd_data1",  32'(bus.o_tx_data),  32'hBE);
        tick();
        check("rd_pulse1", 32'(bus.o_tx_start), 32'h0);
        tx_done();
        check("rd_done_busy", 32'(bus.o_busy), 32'h0);
        tick();
        check("rd_done_start", 32'(bus.o_tx_start), 32'h0);

        // tx_done while idle is ignored
        tx_done(); tick();
        check("idle_txd_start", 32'(bus.o_tx_start), 32'h0);
        check("idle_txd_busy",  32'(bus.o_busy),     32'h0);

        // Invalid header: single error pulse, registers intact
        send(8'h55);
        check("bad_hdr_err",  32'(bus.o_error), 32'h1);
        check("bad_hdr_busy", 32'(bus.o_busy),  32'h0);
        tick();
        check("bad_hdr_err_1", 32'(bus.o_error),  32'h0);
        check("bad_hdr_a",     32'(bus.o_data_a), 32'h0102);
        check("bad_hdr_b",     32'(bus.o_data_b), 32'h0101);
        check("bad_hdr_op",    32'(bus.o_op),     32'h22);

        // Target register holds its old value until the final payload byte
        send(8'h08); send(8'hAA);
        check("partial_a", 32'(bus.o_data_a), 32'h0102);
        send(8'hBB);
        check("commit_a", 32'(bus.o_data_a), 32'hBBAA);

        // Payload timeout after exactly TIMEOUT silent cycles
        send(8'h10); send(8'h33);
        check("tout_busy", 32'(bus.o_busy), 32'h1);
        n = 0;
        while (bus.o_error !== 1'b1 && n < int'(TIMEOUT) + 10) begin
            tick();
            n++;
        end
        check("tout_cycles", 32'(n), 32'(TIMEOUT));
        check("tout_err",    32'(bus.o_error),  32'h1);
        check("tout_b",      32'(bus.o_data_b), 32'h0101);
        check("tout_idle",   32'(bus.o_busy),   32'h0);
        tick();
        check("tout_err_1", 32'(bus.o_error), 32'h0);

        // Reset during WAIT_TX, then a fresh read starts from byte 0
        bus.i_alu_result = 16'hBEEF;
        send(8'h40); tick(); tick(); tx_done(); tick(); tick();
        check("pre_rst_data", 32'(bus.o_tx_data), 32'hBE);
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h40); tick();
        check("rerd_start0", 32'(bus.o_tx_start), 32'h1);
        check("rerd_data0",  32'(bus.o_tx_data),  32'hEF);
        tick(); tx_done(); tick();
        check("rerd_data1", 32'(bus.o_tx_data), 32'hBE);
        tick(); tx_done();
        check("rerd_idle", 32'(bus.o_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
